// File: rtl/cross_bar_pkg.sv
// rtl/cross_bar_pkg.sv - shared types and constants for cross_bar_rr
package cross_bar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_RESP = 2'd2
    } arb_state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam int DEF_NUM_MASTERS = 4;
    localparam int DEF_NUM_SLAVES  = 4;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - per-slave arbiter FSM with rr pointer and grant register (macro CROSS_BAR_PRIO_EN)
module rr_arbiter
    import cross_bar_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] cmd,
    input  logic                   s_ack,
    input  logic                   s_resp,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   in_ack,
    output logic                   in_resp
);

    localparam int PTR_W = $clog2(NUM_MASTERS);
    localparam int IDX_W = PTR_W + 1;

    arb_state_t             state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]       winner;
    logic [IDX_W-1:0]       idx;
    logic                   found;
    logic                   keep_ptr;
    logic                   granted_cmd;

    assign grant       = grant_q;
    assign in_ack      = (state_q == ST_WAIT_ACK);
    assign in_resp     = (state_q == ST_WAIT_RESP);
    assign granted_cmd = |(grant_q & cmd);

    // pick the first requester at or after rr_ptr, wrapping; master 0 overrides when prioritised
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        idx      = '0;
        keep_ptr = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = {1'b0, rr_ptr_q} + IDX_W'(k);
            if (idx >= IDX_W'(NUM_MASTERS)) begin
                idx = idx - IDX_W'(NUM_MASTERS);
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
`ifdef CROSS_BAR_PRIO_EN
        if (req[0]) begin
            winner   = '0;
            keep_ptr = 1'b1;
        end
`endif
    end

    // next-state, next-grant and pointer advance
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d         = ST_WAIT_ACK;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    if (!keep_ptr) begin
                        rr_ptr_d = (winner == PTR_W'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
                    end
                end
            end
            ST_WAIT_ACK: begin
                if (s_ack) begin
                    if (granted_cmd == CMD_WRITE) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = ST_WAIT_RESP;
                    end
                end
            end
            ST_WAIT_RESP: begin
                if (s_resp) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // state, grant and pointer registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/cross_bar_rr.sv
// rtl/cross_bar_rr.sv - NxM crossbar with per-slave round-robin arbitration (macro CROSS_BAR_PRIO_EN)
module cross_bar_rr
    import cross_bar_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_MASTERS-1:0]                  m_req,
    input  logic [NUM_MASTERS-1:0]                  m_cmd,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]      m_addr,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]      m_wdata,
    output logic [NUM_MASTERS-1:0]                  m_ack,
    output logic [NUM_MASTERS-1:0]                  m_resp,
    output logic [NUM_MASTERS-1:0][DATA_W-1:0]      m_rdata,
    output logic [NUM_SLAVES-1:0]                   s_req,
    output logic [NUM_SLAVES-1:0]                   s_cmd,
    output logic [NUM_SLAVES-1:0][ADDR_W-1:0]       s_addr,
    output logic [NUM_SLAVES-1:0][DATA_W-1:0]       s_wdata,
    input  logic [NUM_SLAVES-1:0]                   s_ack,
    input  logic [NUM_SLAVES-1:0]                   s_resp,
    input  logic [NUM_SLAVES-1:0][DATA_W-1:0]       s_rdata,
    output logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0]  grant
);

    localparam int SEL_W = $clog2(NUM_SLAVES);

    logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] slave_req;
    logic [NUM_SLAVES-1:0]                  in_ack;
    logic [NUM_SLAVES-1:0]                  in_resp;

    // decode each master's target slave from the top address bits
    always_comb begin
        slave_req = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            for (int j = 0; j < NUM_SLAVES; j++) begin
                if (m_req[i] && (m_addr[i][ADDR_W-1 -: SEL_W] == SEL_W'(j))) begin
                    slave_req[j][i] = 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_arb
        rr_arbiter #(
            .NUM_MASTERS (NUM_MASTERS)
        ) u_arb (
            .clk     (clk),
            .rst     (rst),
            .req     (slave_req[g]),
            .cmd     (m_cmd),
            .s_ack   (s_ack[g]),
            .s_resp  (s_resp[g]),
            .grant   (grant[g]),
            .in_ack  (in_ack[g]),
            .in_resp (in_resp[g])
        );
    end

    // route granted master to its slave and slave strobes back; everything quiet while in reset
    always_comb begin
        s_req   = '0;
        s_cmd   = '0;
        s_addr  = '0;
        s_wdata = '0;
        m_ack   = '0;
        m_resp  = '0;
        m_rdata = '0;
        if (!rst) begin
            for (int j = 0; j < NUM_SLAVES; j++) begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    if (grant[j][i]) begin
                        s_req[j]   = m_req[i];
                        s_cmd[j]   = m_cmd[i];
                        s_addr[j]  = m_addr[i];
                        s_wdata[j] = m_wdata[i];
                        m_ack[i]   = m_ack[i] | (in_ack[j] & s_ack[j]);
                        if (in_resp[j]) begin
                            m_resp[i]  = m_resp[i] | s_resp[j];
                            m_rdata[i] = s_rdata[j];
                        end
                    end
                end
            end
        end
    end

endmodule
